// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp patterns for the intersection phase controller.
// Pure constants; no logic, no latency, no flow control.
package traffic_pkg;

    localparam logic [2:0] ST_VEH_GREEN  = 3'd0;
    localparam logic [2:0] ST_VEH_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED    = 3'd2;
    localparam logic [2:0] ST_PED_WALK   = 3'd3;
    localparam logic [2:0] ST_NIGHT      = 3'd4;

    typedef enum logic [2:0] {
        VEH_GREEN  = ST_VEH_GREEN,
        VEH_YELLOW = ST_VEH_YELLOW,
        ALL_RED    = ST_ALL_RED,
        PED_WALK   = ST_PED_WALK,
        NIGHT      = ST_NIGHT
    } phase_t;

    localparam logic [2:0] VEH_RED = 3'b100;
    localparam logic [2:0] VEH_YEL = 3'b010;
    localparam logic [2:0] VEH_GRN = 3'b001;

    localparam logic [1:0] PED_WALK_ON = 2'b10;
    localparam logic [1:0] PED_DONT    = 2'b01;
    localparam logic [1:0] PED_DARK    = 2'b00;

    localparam int unsigned CNT_MAX = 31;

endpackage

// File: rtl/phase_timer.sv
// 5-bit loadable down-counter, decrements on tick and saturates at zero.
// Load takes effect next clock; zero flag is combinational from the count.
module phase_timer #(
    parameter logic [4:0] RESET_VAL = 5'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic [4:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != 5'd0)) begin
            count <= count - 5'd1;
        end
    end

    assign zero = (count == 5'd0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: green/yellow/all-red, pedestrian walk and night flash.
// Advances only on the 1 Hz tick; lamp outputs are decoded combinationally from state.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TIME  = 20,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned PED_TIME    = 29,
    parameter int unsigned FLASH_TIME  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_btn,
    input  logic       night_mode,
    output logic [4:0] count_out,
    output logic       light_out_time,
    output logic [2:0] veh_light,
    output logic [1:0] ped_light,
    output logic       ped_ack
);

    if (GREEN_TIME > CNT_MAX || YELLOW_TIME > CNT_MAX || ALLRED_TIME > CNT_MAX ||
        PED_TIME > CNT_MAX || FLASH_TIME > CNT_MAX) begin : g_bad_load
        $error("traffic_phase_controller: load values must be in 0..31");
    end

    localparam logic [4:0] GREEN_LD  = 5'(GREEN_TIME);
    localparam logic [4:0] YELLOW_LD = 5'(YELLOW_TIME);
    localparam logic [4:0] ALLRED_LD = 5'(ALLRED_TIME);
    localparam logic [4:0] PED_LD    = 5'(PED_TIME);
    localparam logic [4:0] FLASH_LD  = 5'(FLASH_TIME);

    phase_t     state, next_state;
    logic       ped_req;
    logic       blink;
    logic       night_exit;
    logic       load;
    logic [4:0] load_val;
    logic       zero;
    logic       enter_walk, enter_night;

    phase_timer #(.RESET_VAL(GREEN_LD)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .count    (count_out),
        .zero     (zero)
    );

    always_comb begin
        next_state     = state;
        load           = 1'b0;
        load_val       = count_out;
        veh_light      = VEH_GRN;
        ped_light      = PED_DONT;
        light_out_time = 1'b1;
        case (state)
            VEH_GREEN: begin
                // Night request outranks a latched walk; the walk is discarded on night entry.
                if (tick && zero) begin
                    if (night_mode) begin
                        next_state = NIGHT;
                        load       = 1'b1;
                        load_val   = 5'd0;
                    end else if (ped_req) begin
                        next_state = VEH_YELLOW;
                        load       = 1'b1;
                        load_val   = YELLOW_LD;
                    end
                end
            end
            VEH_YELLOW: begin
                veh_light = VEH_YEL;
                if (tick && zero) begin
                    next_state = ALL_RED;
                    load       = 1'b1;
                    load_val   = ALLRED_LD;
                end
            end
            ALL_RED: begin
                veh_light = VEH_RED;
                if (tick && zero) begin
                    next_state = night_exit ? VEH_GREEN : PED_WALK;
                    load       = 1'b1;
                    load_val   = night_exit ? GREEN_LD : PED_LD;
                end
            end
            PED_WALK: begin
                veh_light      = VEH_RED;
                ped_light      = (count_out > FLASH_LD) ? PED_WALK_ON : {blink, 1'b0};
                light_out_time = 1'b0;
                if (tick && zero) begin
                    next_state = VEH_GREEN;
                    load       = 1'b1;
                    load_val   = GREEN_LD;
                end
            end
            NIGHT: begin
                veh_light = {1'b0, blink, 1'b0};
                ped_light = PED_DARK;
                if (tick && !night_mode) begin
                    next_state = ALL_RED;
                    load       = 1'b1;
                    load_val   = ALLRED_LD;
                end
            end
            default: begin
                next_state = VEH_GREEN;
                load       = 1'b1;
                load_val   = GREEN_LD;
            end
        endcase
    end

    assign enter_walk  = (state == ALL_RED)   && (next_state == PED_WALK);
    assign enter_night = (state == VEH_GREEN) && (next_state == NIGHT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= VEH_GREEN;
            ped_req    <= 1'b0;
            blink      <= 1'b0;
            ped_ack    <= 1'b0;
            night_exit <= 1'b0;
        end else begin
            state   <= next_state;
            ped_ack <= enter_walk;

            if (enter_walk || enter_night) begin
                ped_req <= 1'b0;
            end else if (ped_btn && (state != PED_WALK) && (state != NIGHT)) begin
                ped_req <= 1'b1;
            end

            // One toggle register serves both the walk flash and the night yellow blink.
            if (enter_walk) begin
                blink <= 1'b0;
            end else if (enter_night) begin
                blink <= 1'b1;
            end else if (tick && (((state == PED_WALK) && (count_out <= FLASH_LD)) ||
                                  (state == NIGHT))) begin
                blink <= ~blink;
            end

            if ((state == NIGHT) && (next_state == ALL_RED)) begin
                night_exit <= 1'b1;
            end else if ((state == ALL_RED) && (next_state != ALL_RED)) begin
                night_exit <= 1'b0;
            end
        end
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Sequences the intersection phases: vehicle green/yellow/all-red, pedestrian walk, and night flashing. Owns the 5-bit phase down-counter that drives `count_out` and `light_out_time` into the pedestrian-signal countdown display path. Advances only on a 1 Hz `tick` strobe from the prescaler. Latches pedestrian button requests and acknowledges them.

Parameters:
- GREEN_TIME, 20: vehicle minimum-green load value (ticks-1).
- YELLOW_TIME, 3: vehicle yellow load value.
- ALLRED_TIME, 1: all-red clearance load value.
- PED_TIME, 29: pedestrian walk load value.
- FLASH_TIME, 5: the walk lamp flashes while count_out <= FLASH_TIME in PED_WALK.
- All load values must be in the range 0..31. A value above 31 is a compile-time error.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-cycle 1 Hz strobe.
- ped_btn, input, 1: pedestrian push button, already debounced (level or pulse).
- night_mode, input, 1: night flashing request.
- count_out, output, 5: current phase down-counter.
- light_out_time, output, 1: 1 means blank the pedestrian countdown.
- veh_light, output, 3: one-hot {red, yellow, green}.
- ped_light, output, 2: {walk, dont_walk}.
- ped_ack, output, 1: one-cycle pulse when the walk phase begins.

Behaviour:
- Clocking: all state updates on the rising edge of clk. Reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - state = VEH_GREEN, count_out = GREEN_TIME.
  - veh_light = 001, ped_light = 01.
  - light_out_time = 1, ped_ack = 0, ped_req = 0.
- Counter rule: on tick, if count_out != 0 then decrement. If count_out == 0, evaluate the transition and load the next state's value in the same cycle.
  - Each timed phase therefore lasts load+1 ticks.
  - Without tick, the counter holds.
  - The counter never wraps below 0.
- States and outputs (veh_light / ped_light / light_out_time):
  - VEH_GREEN: 001 / 01 / 1. On tick with count 0: if night_mode, go to NIGHT (load 0). Else if ped_req, go to VEH_YELLOW (load YELLOW_TIME). Else stay and hold count at 0 (rest in green).
  - VEH_YELLOW: 010 / 01 / 1. On tick with count 0, go to ALL_RED (load ALLRED_TIME).
  - ALL_RED: 100 / 01 / 1. On tick with count 0: if a walk is pending (entered from yellow), go to PED_WALK (load PED_TIME). If entered from NIGHT, go to VEH_GREEN (load GREEN_TIME).
  - PED_WALK: 100 / walk,0 / 0.
    - walk = 1 while count_out > FLASH_TIME.
    - walk toggles on each tick while count_out <= FLASH_TIME, starting at 0 on the first flash tick.
    - On tick with count 0, go to VEH_GREEN (load GREEN_TIME).
  - NIGHT: 0,y,0 / 00 / 1, count_out held 0, where y toggles every tick. On tick with night_mode == 0, go to ALL_RED (load ALLRED_TIME).
- Pedestrian request handling:
  - ped_req is set on any cycle where ped_btn == 1, except in PED_WALK and NIGHT, where presses are ignored.
  - ped_req is cleared on the cycle of the ALL_RED→PED_WALK transition.
  - ped_ack = 1 for exactly that cycle.
  - A press in the same cycle as the clear is dropped.
- Simultaneous events:
  - reset beats tick.
  - At VEH_GREEN count 0, night_mode beats ped_req. ped_req stays latched but is cleared on NIGHT entry.
  - night_mode is sampled only in VEH_GREEN and NIGHT. Mid-cycle requests wait for green.
- Reset mid-operation (for example mid-walk): the next cycle shows the reset values, with no ped_ack.
- Flash toggle register: reset to 0.

Decomposition:
- Shared package `traffic_pkg`:
  - state encoding localparams (VEH_GREEN=0, VEH_YELLOW=1, ALL_RED=2, PED_WALK=3, NIGHT=4).
  - lamp encodings (VEH_RED=3'b100, VEH_YEL=3'b010, VEH_GRN=3'b001, PED_WALK_ON=2'b10, PED_DONT=2'b01).
- One natural sub-module, `phase_timer`: a 5-bit loadable down-counter with tick enable and zero flag.
- FSM, request latch and flash toggle stay in the top module.

Test Plan:
1. Reset, tick every 4 clk, no button for 30 ticks → veh_light=001 throughout, count_out 20 down to 0 then holds 0, light_out_time=1.
2. ped_btn pulse at count 15 in green → 1) yellow at the tick after count reaches 0, count loads 3; 2) ALL_RED after 4 ticks; 3) PED_WALK with count 29 and ped_ack exactly 1 cycle; 4) light_out_time=0.
3. In PED_WALK → walk=1 for counts 29..6. At counts 5..0, walk alternates 0,1,0,1,0,1. Then VEH_GREEN with count 20 and light_out_time=1.
4. ped_btn held high through the entire walk phase → no second walk queued. Green rests at count 0 until a new press.
5. night_mode=1 with ped_req set at green count 0 → 1) NIGHT, with yellow toggling each tick, ped_light=00, ped_req cleared; 2) after night_mode=0, ALL_RED for 2 ticks, then green count 20 with no walk.
6. reset asserted at PED_WALK count 12, together with tick → next cycle count 20, veh_light=001, ped_light=01, ped_ack=0.
